// File: rtl/i2c_pkg.sv
// Shared FSM encoding, bus-event codes and protocol constants for the I2C EEPROM slave.
`timescale 1ns/1ps
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        WADDR,
        WADDR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    typedef enum logic [1:0] {
        BUS_NONE,
        BUS_START,
        BUS_STOP
    } bus_event_t;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'b1010000;
    localparam logic       ACK              = 1'b0;
    localparam logic       NACK             = 1'b1;

    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
        return addr_byte[7:1] == dev;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus SCL edge and START/STOP detection.
`timescale 1ns/1ps
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_raw,
    input  logic       sda_raw,
    output logic       sda_sync,
    output logic       scl_rise,
    output logic       scl_fall,
    output bus_event_t bus_event
);

    logic [1:0] scl_meta;
    logic [1:0] sda_meta;
    logic       scl_prev;
    logic       sda_prev;
    logic       scl_sync;

    // Idle bus is high, so everything resets to 1 to avoid a spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_meta <= 2'b11;
            sda_meta <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_meta <= {scl_meta[0], scl_raw};
            sda_meta <= {sda_meta[0], sda_raw};
            scl_prev <= scl_meta[1];
            sda_prev <= sda_meta[1];
        end
    end

    assign scl_sync = scl_meta[1];
    assign sda_sync = sda_meta[1];
    assign scl_rise = scl_sync & ~scl_prev;
    assign scl_fall = ~scl_sync & scl_prev;

    always_comb begin
        bus_event = BUS_NONE;
        if (scl_sync && scl_prev) begin
            if (sda_prev && !sda_sync)
                bus_event = BUS_START;
            else if (!sda_prev && sda_sync)
                bus_event = BUS_STOP;
        end
    end

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C EEPROM slave: byte-addressed memory behind a 7-bit device address.
// Optional write protect input is enabled by defining EEPROM_WP_EN.
`timescale 1ns/1ps
module i2c_eeprom_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int         ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCL,
    inout  wire               SDA,
`ifdef EEPROM_WP_EN
    input  logic              wp,
`endif
    output logic              busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic              sda_in;
    logic              scl_rise;
    logic              scl_fall;
    bus_event_t        bus_event;

    state_t            state;
    logic [3:0]        bit_cnt;
    logic [7:0]        shift;
    logic [7:0]        tx_shift;
    logic              rw;
    logic              ack_ok;
    logic              sda_low;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        wdata;
    logic [7:0]        rd_data;
    logic [7:0]        mem [0:DEPTH-1];
    logic              write_en;

`ifdef EEPROM_WP_EN
    assign write_en = ~wp;
`else
    assign write_en = 1'b1;
`endif

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_raw   (SCL),
        .sda_raw   (SDA),
        .sda_sync  (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .bus_event (bus_event)
    );

    assign SDA      = sda_low ? 1'b0 : 1'bz;
    assign mem_addr = ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shift    <= 8'd0;
            tx_shift <= 8'd0;
            rw       <= 1'b0;
            ack_ok   <= 1'b0;
            sda_low  <= 1'b0;
            busy     <= 1'b0;
            mem_we   <= 1'b0;
            ptr      <= '0;
            wdata    <= 8'd0;
        end else begin
            mem_we <= 1'b0;
            if (bus_event == BUS_STOP) begin
                state   <= IDLE;
                sda_low <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (bus_event == BUS_START) begin
                state   <= DEV;
                sda_low <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    DEV, WADDR, WDATA: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift   <= {shift[6:0], sda_in};
                            bit_cnt <= bit_cnt + 4'd1;
                            // Data is committed on the 8th rise so a later STOP cannot lose it.
                            if (state == WDATA && bit_cnt == 4'd7 && write_en) begin
                                mem_we <= 1'b1;
                                wdata  <= {shift[6:0], sda_in};
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            case (state)
                                DEV: begin
                                    if (addr_match(shift, DEV_ADDR)) begin
                                        state   <= DEV_ACK;
                                        sda_low <= 1'b1;
                                        busy    <= 1'b1;
                                        rw      <= shift[0];
                                    end else begin
                                        state <= IGNORE;
                                    end
                                end
                                WADDR: begin
                                    state   <= WADDR_ACK;
                                    sda_low <= 1'b1;
                                end
                                default: begin
                                    state   <= WDATA_ACK;
                                    sda_low <= write_en;
                                end
                            endcase
                        end
                    end
                    DEV_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                state    <= RDATA;
                                sda_low  <= ~rd_data[7];
                                tx_shift <= {rd_data[6:0], 1'b0};
                                bit_cnt  <= 4'd1;
                            end else begin
                                state   <= WADDR;
                                sda_low <= 1'b0;
                            end
                        end
                    end
                    WADDR_ACK: begin
                        if (scl_fall) begin
                            ptr     <= ADDR_W'(shift);
                            sda_low <= 1'b0;
                            state   <= WDATA;
                        end
                    end
                    WDATA_ACK: begin
                        if (scl_fall) begin
                            ptr     <= ptr + ADDR_W'(1);
                            sda_low <= 1'b0;
                            state   <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_low <= 1'b0;
                                ack_ok  <= 1'b0;
                                state   <= RDATA_ACK;
                            end else begin
                                sda_low  <= ~tx_shift[7];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RDATA_ACK: begin
                        // Advance on the ACK rise so rd_data is ready by the following fall.
                        if (scl_rise && sda_in == ACK) begin
                            ptr    <= ptr + ADDR_W'(1);
                            ack_ok <= 1'b1;
                        end else if (scl_fall) begin
                            if (ack_ok) begin
                                state    <= RDATA;
                                sda_low  <= ~rd_data[7];
                                tx_shift <= {rd_data[6:0], 1'b0};
                                bit_cnt  <= 4'd1;
                            end else begin
                                sda_low <= 1'b0;
                                state   <= IGNORE;
                            end
                        end
                    end
                    default: begin
                        sda_low <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[ptr] <= wdata;
        rd_data <= mem[ptr];
    end

endmodule

// File: doc/i2c_eeprom_slave.md
I2C_EEPROM_SLAVE -- requirements
Module: i2c_eeprom_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'b1010000, the 7-bit device address this slave answers to.
REQ-002 SHALL have parameter ADDR_W, default 8, the word-address width; memory depth is 2**ADDR_W bytes.
REQ-003 SHALL have port clk, input, 1, system clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port SCL, input, 1, I2C clock from the master, sampled asynchronously.
REQ-006 SHALL have port SDA, inout, 1, open-drain I2C data; the slave drives only 1'b0 or 1'bz.
REQ-007 SHALL have port busy, output, 1, high from an addressed START until the following STOP or START.
REQ-008 SHALL have port mem_we, output, 1, one-clk pulse when a data byte is committed to memory.
REQ-009 SHALL have port mem_addr, output, ADDR_W, the current internal address pointer.

Function
REQ-010 SHALL pass SCL and SDA through 2-flop synchronizers, with SCL rise/fall edges detected on the synchronized copies; clk SHALL be at least 8x the SCL rate.
REQ-011 SHALL detect START as synchronized SDA falling while SCL is high, and STOP as SDA rising while SCL is high; both SHALL be honoured in every state.
REQ-012 SHALL use the FSM states IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-013 SHALL shift data in MSB-first on SCL rising edges, and SHALL change its SDA drive only on a clk following a detected SCL falling edge.
REQ-014 SHALL, on START, enter DEV; after 8 bits, it SHALL ACK (drive 0 for one SCL bit) if bits[7:1]==DEV_ADDR, otherwise enter IGNORE with SDA released.
REQ-015 SHALL, with R/W=0, go DEV_ACK->WADDR; after WADDR_ACK, it SHALL load the pointer with the received byte (low ADDR_W bits) and enter WDATA.
REQ-016 SHALL, for each byte received in WDATA, write mem[ptr], pulse mem_we in the clk of the 8th SCL rise, ACK, increment ptr, and return to WDATA.
REQ-017 SHALL, with R/W=1, enter RDATA after DEV_ACK and drive mem[ptr] MSB-first; bit 7 appears after the ACK bit's SCL fall.
REQ-018 SHALL, in RDATA_ACK, sample the master's bit: 0 increments ptr and sends the next byte; 1 (NACK) releases SDA and enters IGNORE.
REQ-019 SHALL support random read (write phase with a word address, then repeated START with R/W=1, reading from the loaded ptr) and current-address read.
REQ-020 SHALL wrap ptr from 2**ADDR_W-1 to 0 on reads and writes alike.
REQ-021 SHALL, on STOP, release SDA, return to IDLE and drop busy; a partial byte SHALL be discarded with no memory write.
REQ-022 SHALL, on a repeated START, go to DEV in any state while preserving ptr.
REQ-023 SHALL, on a STOP in the same clk as an SCL edge, give STOP priority.

Reset
REQ-024 SHALL, on rst, immediately (without clk) set state=IDLE, SDA=z, busy=0, mem_we=0, ptr=0, and clear the shift register and bit counter; memory contents are not cleared.
REQ-025 SHALL, if reset is asserted mid-transfer, abort the transfer and ignore the bus until the next START.

Configuration
REQ-026 SHALL, with macro EEPROM_WP_EN defined, add input port wp (1 bit); while wp=1, data bytes in WDATA are NACKed, not written, and mem_we stays 0, while address bytes are still ACKed and the ptr still increments.
REQ-027 SHALL, without EEPROM_WP_EN, have no wp port and leave all writes enabled.

Structure
REQ-028 SHALL place the FSM state encoding, DEV_ADDR default, and START/STOP/ACK constants in a shared package, i2c_pkg.
REQ-029 SHALL put the synchronizer and START/STOP/edge detection in sub-module i2c_bus_sync; the FSM and the memory array reside in i2c_eeprom_slave.

Verification
REQ-030 SHALL pass a single write: START, 0xA0, 0x10, 0x5A, STOP -> three ACKs, one mem_we pulse with mem_addr=0x10, mem[0x10]=0x5A.
REQ-031 SHALL pass a random read: write ptr 0x10, repeated START, 0xA1 -> slave returns 0x5A; master NACK -> SDA released, then STOP -> busy=0.
REQ-032 SHALL pass a wrong address: START, 0xA2 -> ACK bit reads 1 (NACK), no mem_we, SDA z until the next START.
REQ-033 SHALL pass a wrap-around: write at 0xFF with data 0x11, 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22, ptr=0x01.
REQ-034 SHALL pass an abort: STOP after 4 data bits -> no mem_we, state IDLE; rst asserted mid-read -> SDA z within the same cycle.
REQ-035 SHALL pass a write protect (EEPROM_WP_EN, wp=1): write 0x77 to 0x20 -> data NACKed, mem[0x20] unchanged.
